// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the arbitrated ALU
// and the arithmetic engine it drives.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_OR   = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_NOR  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_ILL6 = 3'b110;
    localparam logic [2:0] OP_ILL7 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/arithmetic_engine.sv
// Purely combinational 8-bit logic/arithmetic unit; unknown opcodes yield zero.
module arithmetic_engine
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_instruction,
    output logic [DATA_W-1:0] out
);

    // ADD and SUB wrap modulo 256; carry and borrow are discarded
    always_comb begin
        out = '0;
        case (i_instruction)
            OP_OR:   out = i_a | i_b;
            OP_NAND: out = ~(i_a & i_b);
            OP_NOR:  out = ~(i_a | i_b);
            OP_AND:  out = i_a & i_b;
            OP_ADD:  out = i_a + i_b;
            OP_SUB:  out = i_a - i_b;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port front end that arbitrates requests onto a single arithmetic_engine,
// keeping exactly one operation in flight and holding its response until taken.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit RR_EN = 1'b1
)
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    input  logic [2:0]        i_req0_op,
    input  logic [DATA_W-1:0] i_req0_a,
    input  logic [DATA_W-1:0] i_req0_b,
    input  logic              i_req1_valid,
    input  logic [2:0]        i_req1_op,
    input  logic [DATA_W-1:0] i_req1_a,
    input  logic [DATA_W-1:0] i_req1_b,
    output logic              o_req0_ready,
    output logic              o_req1_ready,
    output logic              o_rsp_valid,
    output logic              o_rsp_id,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    input  logic              i_rsp_ready
);

    state_t              state_q;
    logic                lastGrant_q;
    logic                id_q;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                rspValid_q;
    logic                rspId_q;
    logic [DATA_W-1:0]   rspData_q;
    logic                rspErr_q;

    logic                anyValid;
    logic                accepting;
    logic                grantId_d;
    logic                opIllegal;
    logic [DATA_W-1:0]   aluOut;

    // A tie goes to the port not served last when round-robin is enabled
    always_comb begin
        grantId_d = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grantId_d = RR_EN ? ~lastGrant_q : 1'b0;
        end else if (i_req1_valid) begin
            grantId_d = 1'b1;
        end
    end

    assign anyValid     = i_req0_valid || i_req1_valid;
    assign accepting    = (state_q == ST_IDLE) && anyValid && !i_rst;
    assign o_req0_ready = accepting && !grantId_d;
    assign o_req1_ready = accepting && grantId_d;

    assign opIllegal = (op_q == OP_ILL6) || (op_q == OP_ILL7);

    arithmetic_engine u_engine (
        .i_a           (a_q),
        .i_b           (b_q),
        .i_instruction (op_q),
        .out           (aluOut)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            lastGrant_q <= 1'b1;
            id_q        <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rspValid_q  <= 1'b0;
            rspId_q     <= 1'b0;
            rspData_q   <= '0;
            rspErr_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (anyValid) begin
                        id_q        <= grantId_d;
                        lastGrant_q <= grantId_d;
                        op_q        <= grantId_d ? i_req1_op : i_req0_op;
                        a_q         <= grantId_d ? i_req1_a  : i_req0_a;
                        b_q         <= grantId_d ? i_req1_b  : i_req0_b;
                        state_q     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rspData_q  <= opIllegal ? '0 : aluOut;
                    rspErr_q   <= opIllegal;
                    rspId_q    <= id_q;
                    rspValid_q <= 1'b1;
                    state_q    <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_rsp_valid = rspValid_q;
    assign o_rsp_id    = rspId_q;
    assign o_rsp_data  = rspData_q;
    assign o_rsp_err   = rspErr_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority to port 0.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous and active-high.
REQ-004 i_req0_valid / i_req1_valid  input  1 each  requester has an operation pending.
REQ-005 i_req0_op / i_req1_op  input  3 each  opcode: OR 000, NAND 001, NOR 010, AND 011, ADD 100, SUB 101.
REQ-006 i_req0_a, i_req0_b / i_req1_a, i_req1_b  input  8 each  operands.
REQ-007 o_req0_ready / o_req1_ready  output  1 each  request accepted this cycle.
REQ-008 o_rsp_valid  output  1  response held.
REQ-009 o_rsp_id  output  1  requester index of the held response.
REQ-010 o_rsp_data  output  8  operation result.
REQ-011 o_rsp_err  output  1  illegal opcode (110, 111).
REQ-012 i_rsp_ready  input  1  consumer takes the response.

Function
REQ-013 FSM states: IDLE, EXEC, RESP; exactly one operation in flight.
REQ-014 IDLE: when any valid is high, grant one requester, assert only its ready combinationally, capture its op/a/b/id, and go to EXEC.
REQ-015 Ready is never asserted outside IDLE; a request transfers only when valid and ready are both high.
REQ-016 RR_EN=1, both valid: grant the port not granted last; last-grant flop resets to 1, so port 0 wins the first tie.
REQ-017 RR_EN=0, both valid: port 0 always wins.
REQ-018 Single valid: grant that port regardless of last-grant.
REQ-019 EXEC (one cycle): register the ALU output of captured operands into o_rsp_data, set o_rsp_err for opcodes 110/111 (data forced 00), go to RESP.
REQ-020 RESP: o_rsp_valid=1; data, id and err stay stable until i_rsp_ready=1.
REQ-021 RESP with i_rsp_ready=1: go to IDLE; o_rsp_valid low next cycle.
REQ-022 Latency: accept edge, then response valid two edges later; best-case throughput is one operation per 3 cycles.
REQ-023 Arithmetic is 8-bit modulo 256, with no carry or borrow out: FF+01=00, 00-01=FF.
REQ-024 Operands are captured at accept; later changes on request inputs do not affect the in-flight result.
REQ-025 A requester that drops valid before ready is not granted, and no response is generated.

Reset
REQ-026 Asserting i_rst at any time, including mid-operation, immediately forces: state IDLE, o_rsp_valid=0, o_rsp_data=00, o_rsp_id=0, o_rsp_err=0, last-grant=1, captured operands 00.
REQ-027 While i_rst is high, both readys are 0.
REQ-028 An in-flight operation aborted by reset produces no response after deassertion.
REQ-029 First grant is possible on the first rising edge after deassertion.

Structure
REQ-030 Opcode localparams and FSM state encodings live in a shared package alu_pkg, also used by arithmetic_engine and benches.
REQ-031 The datapath is one instance of the existing arithmetic_engine (i_a, i_b, i_instruction, out), driven from the captured registers; no duplicate ALU logic.
REQ-032 The illegal-opcode check and arbitration logic stay inside alu_arbiter.

Verification
REQ-033 Port 0 only, OR AA,55 with i_rsp_ready=1 -> rsp_valid two edges after accept, data FF, id 0, err 0.
REQ-034 Both valid from reset (port 0 ADD FF,01; port 1 SUB 00,01) with RR_EN=1 -> port 0 gets data 00, then port 1 gets FF; repeat both -> port 0 first again (alternation).
REQ-035 RR_EN=0, both continuously valid, three operations -> all granted to port 0; port 1 ready never asserted.
REQ-036 NAND FF,FF with i_rsp_ready held low 5 cycles -> rsp_valid, data 00, id stable for 5 cycles; readys stay 0; IDLE after the ready cycle.
REQ-037 Op 111 on port 1 -> data 00, err 1, id 1; next legal op (NOR 80,C4 -> 3B) has err 0.
REQ-038 i_rst pulsed during EXEC of ADD 55,55 -> outputs zero immediately; no response with data AA after release.
